agc_scheduler: RTL and testbench
================================

Name: agc_scheduler

Overview:
- Sequences the 4-bit analog-gain AGC of the line-sensor front end.
- Watches the 10-bit pixel stream of each sensor line and tracks the line peak.
- At line end, issues a one-cycle update strobe with that peak to the AGC.
- After any gain change, holds off further updates for a programmable number of lines so the analog chain can settle.

Parameters:
- SETTLE_LINES, 2, number of complete lines (line_end events) to ignore after a gain change; 0 means no hold-off; range 0..255.
- MIN_PIX, 16, minimum count of valid pixels in a line for its peak to be used; shorter lines are discarded.

Ports:
- clk_in  input  1  system clock; all logic rising-edge.
- reset_in  input  1  synchronous, active-high reset.
- enable_in  input  1  1 = scheduling active; 0 = forced to IDLE.
- line_start  input  1  one-cycle pulse, first cycle of a sensor line.
- line_end  input  1  one-cycle pulse, last cycle of a sensor line.
- pix_valid  input  1  pix_data is a valid pixel this cycle.
- pix_data  input  10  pixel amplitude, unsigned.
- gain_in  input  4  current gain reported back by the AGC.
- agc_update  output  1  one-cycle strobe to the AGC update input.
- agc_data  output  10  peak value presented to the AGC data input.
- peak_out  output  10  last evaluated line peak, held.
- peak_valid  output  1  one-cycle pulse coincident with agc_update.
- settling  output  1  high while in SETTLE.

Behaviour:
- Reset (reset_in=1 at a clock edge):
  - State goes to IDLE.
  - Peak register and pixel counter clear to 0.
  - agc_update, peak_valid and settling clear to 0.
  - agc_data and peak_out clear to 0.
  - Reset has priority over every other input.
- Registers and outputs: all outputs are registered. Pixel counter is 12-bit and saturates at 4095.
- IDLE: leave to WAIT_LINE when enable_in=1.
- WAIT_LINE: on line_start go to ACQUIRE.
  - Peak is loaded with pix_data if pix_valid is set the same cycle, else 0.
  - Counter is loaded with 1 or 0 accordingly.
  - line_end and pix_valid are ignored when there is no line_start.
- ACQUIRE: each pix_valid cycle does peak <= max(peak, pix_data) and count+1.
  - A pixel on the line_end cycle is included.
  - A repeated line_start restarts accumulation, loading as in WAIT_LINE.
  - On line_end: snapshot gain_in into gain_snap.
  - If count (including that cycle's pixel) >= MIN_PIX, go to EVAL; otherwise go to WAIT_LINE with no strobe.
  - line_start and line_end in the same cycle: line_end wins, the line closes.
- EVAL (exactly one cycle, latency 1 after line_end):
  - agc_update=1, peak_valid=1, agc_data=final peak, peak_out=final peak.
  - Next state is CHECK.
  - agc_data and peak_out hold their value until the next EVAL.
- CHECK (one cycle, two cycles after line_end): compare gain_in with gain_snap.
  - If they differ and SETTLE_LINES>0, go to SETTLE and load the line counter with SETTLE_LINES.
  - Otherwise go to WAIT_LINE.
  - Pulses arriving during EVAL or CHECK are not captured; that line is lost.
- SETTLE: settling=1; each line_end decrements the counter.
  - When a line_end arrives with counter=1, go to WAIT_LINE the next cycle.
  - line_start and pixels are ignored.
- enable_in=0 in any state: go to IDLE next edge.
  - An in-progress line is discarded with no strobe.
  - settling drops with the state change.
  - peak_out is retained.
- Re-enable: always begins in WAIT_LINE, so a partial line is never evaluated.
- Update rate: agc_update never asserts more than once per line.
- Strobe spacing: consecutive strobes are at least 1 line apart when the gain is unchanged, and at least SETTLE_LINES+1 lines apart after a change.

Test Plan:
- Reset then enable; line of 32 pixels with max 0x2A0 (672) -> agc_update=1, agc_data=672 one cycle after line_end; gain_in 0->1 seen in CHECK -> settling=1 for exactly 2 following line_ends, then the next line evaluates.
- Line of 32 pixels with max 850 and gain_in unchanged -> strobe with agc_data=850, settling stays 0, the next line is evaluated immediately.
- Line with only 10 valid pixels (MIN_PIX=16) -> no agc_update, no peak_valid; peak_out keeps its previous value.
- line_start mid-line (first partial line max 1020, restarted line max 500, 20 pixels) -> agc_data=500; pixel on the line_end cycle of 900 -> agc_data=900.
- enable_in dropped during ACQUIRE and during SETTLE -> no strobe, IDLE next cycle, settling=0; re-enable mid-line -> that line is ignored, the next full line is evaluated.
- reset_in asserted in EVAL -> agc_update=0 that edge onward; all outputs 0, state IDLE; SETTLE_LINES=0 build: gain change -> settling never asserts.

Source files
------------

// File: rtl/agc_scheduler.sv
// Line-peak AGC scheduler: tracks the peak of each sensor line, strobes it to the
// analog AGC at line end, and holds off further updates while the gain settles.
module agc_scheduler #(
  parameter int SETTLE_LINES = 2,
  parameter int MIN_PIX      = 16
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       enable_in,
  input  logic       line_start,
  input  logic       line_end,
  input  logic       pix_valid,
  input  logic [9:0] pix_data,
  input  logic [3:0] gain_in,
  output logic       agc_update,
  output logic [9:0] agc_data,
  output logic [9:0] peak_out,
  output logic       peak_valid,
  output logic       settling
);

  localparam logic [11:0] MIN_PIX_C  = 12'(MIN_PIX);
  localparam logic [7:0]  SETTLE_C   = 8'(SETTLE_LINES);
  localparam logic [11:0] CNT_MAX_C  = 12'hFFF;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LINE = 3'd1,
    ST_ACQUIRE   = 3'd2,
    ST_EVAL      = 3'd3,
    ST_CHECK     = 3'd4,
    ST_SETTLE    = 3'd5
  } state_t;

  state_t      state_r;
  logic [9:0]  peak_r;
  logic [11:0] cnt_r;
  logic [3:0]  gain_snap_r;
  logic [7:0]  settle_cnt_r;

  logic [9:0]  acc_peak_s;
  logic [11:0] acc_cnt_s;
  logic [9:0]  first_peak_s;
  logic [11:0] first_cnt_s;

  // Peak/count as they would stand after including this cycle's pixel
  always_comb begin
    acc_peak_s   = peak_r;
    acc_cnt_s    = cnt_r;
    first_peak_s = 10'd0;
    first_cnt_s  = 12'd0;
    if (pix_valid && (pix_data > peak_r)) begin
      acc_peak_s = pix_data;
    end else begin
      acc_peak_s = peak_r;
    end
    if (pix_valid && (cnt_r != CNT_MAX_C)) begin
      acc_cnt_s = cnt_r + 12'd1;
    end else begin
      acc_cnt_s = cnt_r;
    end
    if (pix_valid) begin
      first_peak_s = pix_data;
      first_cnt_s  = 12'd1;
    end else begin
      first_peak_s = 10'd0;
      first_cnt_s  = 12'd0;
    end
  end

  // Scheduler state machine with registered outputs
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_r      <= ST_IDLE;
      peak_r       <= 10'd0;
      cnt_r        <= 12'd0;
      gain_snap_r  <= 4'd0;
      settle_cnt_r <= 8'd0;
      agc_update   <= 1'b0;
      peak_valid   <= 1'b0;
      settling     <= 1'b0;
      agc_data     <= 10'd0;
      peak_out     <= 10'd0;
    end else begin
      agc_update <= 1'b0;
      peak_valid <= 1'b0;
      if (!enable_in) begin
        state_r  <= ST_IDLE;
        settling <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: state_r <= ST_WAIT_LINE;
          ST_WAIT_LINE: begin
            if (line_start) begin
              state_r <= ST_ACQUIRE;
              peak_r  <= first_peak_s;
              cnt_r   <= first_cnt_s;
            end
          end
          ST_ACQUIRE: begin
            // line_end takes precedence over a coincident line_start
            if (line_end) begin
              gain_snap_r <= gain_in;
              if (acc_cnt_s >= MIN_PIX_C) begin
                state_r    <= ST_EVAL;
                agc_update <= 1'b1;
                peak_valid <= 1'b1;
                agc_data   <= acc_peak_s;
                peak_out   <= acc_peak_s;
              end else begin
                state_r <= ST_WAIT_LINE;
              end
            end else if (line_start) begin
              peak_r <= first_peak_s;
              cnt_r  <= first_cnt_s;
            end else begin
              peak_r <= acc_peak_s;
              cnt_r  <= acc_cnt_s;
            end
          end
          ST_EVAL: state_r <= ST_CHECK;
          ST_CHECK: begin
            if ((gain_in != gain_snap_r) && (SETTLE_C != 8'd0)) begin
              state_r      <= ST_SETTLE;
              settle_cnt_r <= SETTLE_C;
              settling     <= 1'b1;
            end else begin
              state_r <= ST_WAIT_LINE;
            end
          end
          ST_SETTLE: begin
            if (line_end) begin
              if (settle_cnt_r == 8'd1) begin
                state_r  <= ST_WAIT_LINE;
                settling <= 1'b0;
              end else begin
                settle_cnt_r <= settle_cnt_r - 8'd1;
              end
            end
          end
          default: begin
            state_r  <= ST_IDLE;
            settling <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_agc_scheduler.sv
// Directed self-checking bench for agc_scheduler; a second instance is built with
// no settle hold-off and shares all inputs.
module tb_agc_scheduler;

  logic       clk_in = 1'b0;
  logic       reset_in, enable_in, line_start, line_end, pix_valid;
  logic [9:0] pix_data;
  logic [3:0] gain_in;
  logic       agc_update, peak_valid, settling;
  logic [9:0] agc_data, peak_out;
  logic       agc_update2, peak_valid2, settling2;
  logic [9:0] agc_data2, peak_out2;

  int n_vec = 0;
  int n_err = 0;
  int strobe_cnt = 0;
  logic settle2_seen = 1'b0;
  int s0;

  agc_scheduler dut (
    .clk_in(clk_in), .reset_in(reset_in), .enable_in(enable_in),
    .line_start(line_start), .line_end(line_end), .pix_valid(pix_valid),
    .pix_data(pix_data), .gain_in(gain_in), .agc_update(agc_update),
    .agc_data(agc_data), .peak_out(peak_out), .peak_valid(peak_valid),
    .settling(settling)
  );

  agc_scheduler #(.SETTLE_LINES(0)) dut2 (
    .clk_in(clk_in), .reset_in(reset_in), .enable_in(enable_in),
    .line_start(line_start), .line_end(line_end), .pix_valid(pix_valid),
    .pix_data(pix_data), .gain_in(gain_in), .agc_update(agc_update2),
    .agc_data(agc_data2), .peak_out(peak_out2), .peak_valid(peak_valid2),
    .settling(settling2)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    if (agc_update) strobe_cnt <= strobe_cnt + 1;
    if (settling2) settle2_seen <= 1'b1;
  end

  // Apply one cycle of inputs; returns 1 time unit after the capturing edge
  task automatic drive(input logic ls, input logic le, input logic pv, input logic [9:0] pd);
    line_start = ls; line_end = le; pix_valid = pv; pix_data = pd;
    @(posedge clk_in); #1;
    line_start = 1'b0; line_end = 1'b0; pix_valid = 1'b0; pix_data = 10'd0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, 10'd0);
  endtask

  // n valid pixels, line_end on the last one, value mx at index midx, others < 64
  task automatic send_line(input int n, input logic [9:0] mx, input int midx);
    for (int i = 0; i < n; i++)
      drive(i == 0, i == n - 1, 1'b1, (i == midx) ? mx : 10'(i & 63));
  endtask

  task automatic test_reset;
    reset_in = 1'b1; enable_in = 1'b0; gain_in = 4'd0;
    idle(2);
    n_vec++; if (agc_update !== 1'b0) begin n_err++; $display("FAIL rst_update got %0b want 0", agc_update); end
    n_vec++; if (peak_valid !== 1'b0) begin n_err++; $display("FAIL rst_peak_valid got %0b want 0", peak_valid); end
    n_vec++; if (settling !== 1'b0) begin n_err++; $display("FAIL rst_settling got %0b want 0", settling); end
    n_vec++; if (agc_data !== 10'd0) begin n_err++; $display("FAIL rst_agc_data got %0d want 0", agc_data); end
    n_vec++; if (peak_out !== 10'd0) begin n_err++; $display("FAIL rst_peak_out got %0d want 0", peak_out); end
    reset_in = 1'b0; enable_in = 1'b1;
    idle(1);
  endtask

  task automatic test_gain_change;
    s0 = strobe_cnt;
    send_line(32, 10'd672, 16);
    n_vec++; if (agc_update !== 1'b1) begin n_err++; $display("FAIL gc_update got %0b want 1", agc_update); end
    n_vec++; if (peak_valid !== 1'b1) begin n_err++; $display("FAIL gc_peak_valid got %0b want 1", peak_valid); end
    n_vec++; if (agc_data !== 10'd672) begin n_err++; $display("FAIL gc_agc_data got %0d want 672", agc_data); end
    gain_in = 4'd1;
    idle(1);
    n_vec++; if (agc_update !== 1'b0) begin n_err++; $display("FAIL gc_one_cycle got %0b want 0", agc_update); end
    idle(1);
    n_vec++; if (settling !== 1'b1) begin n_err++; $display("FAIL gc_settling got %0b want 1", settling); end
    send_line(32, 10'd100, 5);
    n_vec++; if (settling !== 1'b1) begin n_err++; $display("FAIL gc_settle_1 got %0b want 1", settling); end
    send_line(32, 10'd200, 5);
    n_vec++; if (settling !== 1'b0) begin n_err++; $display("FAIL gc_settle_2 got %0b want 0", settling); end
    n_vec++; if (strobe_cnt !== s0 + 1) begin n_err++; $display("FAIL gc_strobes got %0d want %0d", strobe_cnt, s0 + 1); end
    send_line(32, 10'd300, 8);
    n_vec++; if (agc_update !== 1'b1 || agc_data !== 10'd300) begin n_err++; $display("FAIL gc_after_settle got %0b/%0d want 1/300", agc_update, agc_data); end
    idle(2);
  endtask

  task automatic test_steady;
    send_line(32, 10'd850, 20);
    n_vec++; if (agc_update !== 1'b1 || agc_data !== 10'd850) begin n_err++; $display("FAIL st_850 got %0b/%0d want 1/850", agc_update, agc_data); end
    idle(2);
    n_vec++; if (settling !== 1'b0) begin n_err++; $display("FAIL st_settling got %0b want 0", settling); end
    send_line(32, 10'd333, 9);
    n_vec++; if (agc_update !== 1'b1 || agc_data !== 10'd333) begin n_err++; $display("FAIL st_next got %0b/%0d want 1/333", agc_update, agc_data); end
    n_vec++; if (peak_out !== 10'd333) begin n_err++; $display("FAIL st_peak_out got %0d want 333", peak_out); end
    idle(2);
  endtask

  task automatic test_short_line;
    s0 = strobe_cnt;
    send_line(10, 10'd700, 5);
    n_vec++; if (agc_update !== 1'b0 || peak_valid !== 1'b0) begin n_err++; $display("FAIL sh_strobe got %0b/%0b want 0/0", agc_update, peak_valid); end
    idle(2);
    n_vec++; if (peak_out !== 10'd333) begin n_err++; $display("FAIL sh_peak_out got %0d want 333", peak_out); end
    n_vec++; if (strobe_cnt !== s0) begin n_err++; $display("FAIL sh_strobes got %0d want %0d", strobe_cnt, s0); end
  endtask

  task automatic test_restart;
    drive(1'b1, 1'b0, 1'b1, 10'd5);
    drive(1'b0, 1'b0, 1'b1, 10'd1020);
    drive(1'b0, 1'b0, 1'b1, 10'd7);
    send_line(20, 10'd500, 10);
    n_vec++; if (agc_update !== 1'b1 || agc_data !== 10'd500) begin n_err++; $display("FAIL rs_restart got %0b/%0d want 1/500", agc_update, agc_data); end
    idle(2);
    send_line(20, 10'd900, 19);
    n_vec++; if (agc_data !== 10'd900 || peak_out !== 10'd900) begin n_err++; $display("FAIL rs_end_pixel got %0d/%0d want 900/900", agc_data, peak_out); end
    idle(2);
  endtask

  task automatic test_enable;
    s0 = strobe_cnt;
    drive(1'b1, 1'b0, 1'b1, 10'd40);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, 10'd50);
    enable_in = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 10'd60);
    n_vec++; if (settling !== 1'b0 || agc_update !== 1'b0) begin n_err++; $display("FAIL en_acq_drop got %0b/%0b want 0/0", settling, agc_update); end
    enable_in = 1'b1;
    for (int i = 0; i < 25; i++) drive(1'b0, i == 24, 1'b1, 10'd990);
    idle(2);
    n_vec++; if (strobe_cnt !== s0) begin n_err++; $display("FAIL en_partial_strobes got %0d want %0d", strobe_cnt, s0); end
    n_vec++; if (peak_out !== 10'd900) begin n_err++; $display("FAIL en_peak_kept got %0d want 900", peak_out); end
    send_line(32, 10'd400, 3);
    n_vec++; if (agc_update !== 1'b1 || agc_data !== 10'd400) begin n_err++; $display("FAIL en_next_line got %0b/%0d want 1/400", agc_update, agc_data); end
    idle(2);
    send_line(32, 10'd123, 3);
    gain_in = 4'd2;
    idle(2);
    n_vec++; if (settling !== 1'b1) begin n_err++; $display("FAIL en_settle_enter got %0b want 1", settling); end
    enable_in = 1'b0;
    idle(1);
    n_vec++; if (settling !== 1'b0) begin n_err++; $display("FAIL en_settle_drop got %0b want 0", settling); end
    enable_in = 1'b1;
    idle(1);
    send_line(32, 10'd456, 7);
    n_vec++; if (agc_update !== 1'b1 || agc_data !== 10'd456) begin n_err++; $display("FAIL en_reenable got %0b/%0d want 1/456", agc_update, agc_data); end
    idle(2);
    n_vec++; if (settling !== 1'b0) begin n_err++; $display("FAIL en_no_settle got %0b want 0", settling); end
  endtask

  task automatic test_reset_in_eval;
    send_line(20, 10'd777, 4);
    n_vec++; if (agc_update !== 1'b1) begin n_err++; $display("FAIL re_eval got %0b want 1", agc_update); end
    reset_in = 1'b1;
    idle(1);
    n_vec++; if (agc_update !== 1'b0 || peak_valid !== 1'b0 || settling !== 1'b0) begin n_err++; $display("FAIL re_flags got %0b%0b%0b want 000", agc_update, peak_valid, settling); end
    n_vec++; if (agc_data !== 10'd0 || peak_out !== 10'd0) begin n_err++; $display("FAIL re_data got %0d/%0d want 0/0", agc_data, peak_out); end
    reset_in = 1'b0;
    idle(1);
    send_line(20, 10'd111, 2);
    n_vec++; if (agc_update !== 1'b1 || agc_data !== 10'd111) begin n_err++; $display("FAIL re_resume got %0b/%0d want 1/111", agc_update, agc_data); end
    idle(2);
  endtask

  task automatic test_settle_zero;
    gain_in = 4'd3;
    send_line(32, 10'd222, 6);
    n_vec++; if (agc_update2 !== 1'b1 || agc_data2 !== 10'd222) begin n_err++; $display("FAIL s0_strobe got %0b/%0d want 1/222", agc_update2, agc_data2); end
    gain_in = 4'd4;
    idle(2);
    n_vec++; if (settling2 !== 1'b0) begin n_err++; $display("FAIL s0_settling got %0b want 0", settling2); end
    n_vec++; if (settling !== 1'b1) begin n_err++; $display("FAIL s0_ref_settling got %0b want 1", settling); end
    n_vec++; if (settle2_seen !== 1'b0) begin n_err++; $display("FAIL s0_ever_settled got %0b want 0", settle2_seen); end
  endtask

  initial begin
    line_start = 1'b0; line_end = 1'b0; pix_valid = 1'b0; pix_data = 10'd0;
    test_reset;
    test_gain_change;
    test_steady;
    test_short_line;
    test_restart;
    test_enable;
    test_reset_in_eval;
    test_settle_zero;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
